// File: rtl/reorder_buffer_pkg.sv
// Shared configuration, tag/entry types and tag<->index helpers for the reorder buffer.
// Tags are index+1 so that tag 0 can mean "value comes from the register file".
package reorder_buffer_pkg;

  localparam int ROB_SZ = 8;
  localparam int XLEN   = 32;
  localparam int TAG_W  = $clog2(ROB_SZ + 1);
  localparam int CNT_W  = $clog2(ROB_SZ + 1);
  localparam int IDX_W  = $clog2(ROB_SZ);
  localparam int REG_W  = 5;

  typedef logic [TAG_W-1:0] ROB_TAG;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic [REG_W-1:0] dest_reg;
    logic             has_dest;
    logic [XLEN-1:0]  value;
  } ROB_ENTRY;

  typedef struct packed {
    ROB_TAG          dp_tag;
    logic            ready_a;
    logic [XLEN-1:0] value_a;
    logic            ready_b;
    logic [XLEN-1:0] value_b;
  } ROB_RS_PACKET;

  function automatic ROB_TAG idx_to_tag(input logic [IDX_W-1:0] idx);
    return ROB_TAG'(idx) + ROB_TAG'(1);
  endfunction

  function automatic logic [IDX_W-1:0] tag_to_idx(input ROB_TAG tag);
    return IDX_W'(tag - ROB_TAG'(1));
  endfunction

  // Tags above ROB_SZ are representable in TAG_W bits but name no entry.
  function automatic logic tag_in_range(input ROB_TAG tag);
    return (tag != '0) && (tag <= ROB_TAG'(ROB_SZ));
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, dependency lookup, CDB, squash and retire signals of the reorder buffer.
// The ROB is the slave; the core pipeline (or a bench) drives it as master.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic             dp_valid;
  logic [REG_W-1:0] dp_dest_reg;
  logic             dp_has_dest;
  logic             dp_ready;
  ROB_TAG           dp_tag;

  ROB_TAG           dep_tag_a;
  ROB_TAG           dep_tag_b;
  logic             dep_ready_a;
  logic             dep_ready_b;
  logic [XLEN-1:0]  dep_value_a;
  logic [XLEN-1:0]  dep_value_b;

  logic             cdb_valid;
  ROB_TAG           cdb_tag;
  logic [XLEN-1:0]  cdb_value;

  logic             squash;

  logic             retire_valid;
  ROB_TAG           retire_tag;
  logic [REG_W-1:0] retire_dest_reg;
  logic             retire_has_dest;
  logic [XLEN-1:0]  retire_value;
  logic [CNT_W-1:0] count;

  modport slave (
    input  dp_valid, dp_dest_reg, dp_has_dest,
    output dp_ready, dp_tag,
    input  dep_tag_a, dep_tag_b,
    output dep_ready_a, dep_ready_b, dep_value_a, dep_value_b,
    input  cdb_valid, cdb_tag, cdb_value,
    input  squash,
    output retire_valid, retire_tag, retire_dest_reg, retire_has_dest, retire_value,
    output count
  );

  modport master (
    output dp_valid, dp_dest_reg, dp_has_dest,
    input  dp_ready, dp_tag,
    output dep_tag_a, dep_tag_b,
    input  dep_ready_a, dep_ready_b, dep_value_a, dep_value_b,
    output cdb_valid, cdb_tag, cdb_value,
    output squash,
    input  retire_valid, retire_tag, retire_dest_reg, retire_has_dest, retire_value,
    input  count
  );

endinterface

// File: rtl/reorder_buffer_dep_lookup.sv
// Combinational operand lookup: tag -> ready/value from ROB storage, with same-cycle
// CDB bypass so an operand produced this cycle is not missed at dispatch.
module rob_dep_lookup
  import reorder_buffer_pkg::*;
(
  input  ROB_TAG            tag,
  input  logic [ROB_SZ-1:0] busy_vec,
  input  logic [ROB_SZ-1:0] done_vec,
  input  logic [XLEN-1:0]   value_arr [ROB_SZ],
  input  logic              cdb_valid,
  input  ROB_TAG            cdb_tag,
  input  logic [XLEN-1:0]   cdb_value,
  output logic              ready,
  output logic [XLEN-1:0]   value
);

  logic [IDX_W-1:0] idx;
  logic             hit;

  always_comb begin
    ready = 1'b0;
    value = '0;
    idx   = tag_to_idx(tag);
    hit   = cdb_valid && (cdb_tag == tag);
    // Value is forced to zero whenever the operand is not ready.
    if (tag_in_range(tag) && busy_vec[idx] && (done_vec[idx] || hit)) begin
      ready = 1'b1;
      value = hit ? cdb_value : value_arr[idx];
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at dispatch, captures CDB results,
// retires completed head entries in program order, and flushes everything on squash.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input logic        clock,
  input logic        reset,
  reorder_buffer_if.slave rob
);

  ROB_ENTRY         entries [ROB_SZ];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [CNT_W-1:0] count_q;

  logic             dp_ready;
  logic             fire_dp;
  logic             fire_ret;
  logic [IDX_W-1:0] cdb_idx;
  logic             cdb_write;

  logic [ROB_SZ-1:0] busy_vec;
  logic [ROB_SZ-1:0] done_vec;
  logic [XLEN-1:0]   value_arr [ROB_SZ];

  logic              ready_a;
  logic              ready_b;
  logic [XLEN-1:0]   value_a;
  logic [XLEN-1:0]   value_b;
  ROB_RS_PACKET      rs_pkt;

  // Readiness comes from the registered count only, so a full ROB stays closed
  // even while its head retires this cycle.
  assign dp_ready  = (count_q < CNT_W'(ROB_SZ));
  assign fire_dp   = rob.dp_valid && dp_ready;
  assign fire_ret  = entries[head].busy && entries[head].done && !rob.squash;
  assign cdb_idx   = tag_to_idx(rob.cdb_tag);
  assign cdb_write = rob.cdb_valid && tag_in_range(rob.cdb_tag) && entries[cdb_idx].busy;

  always_comb begin
    busy_vec = '0;
    done_vec = '0;
    for (int i = 0; i < ROB_SZ; i++) begin
      busy_vec[i]  = entries[i].busy;
      done_vec[i]  = entries[i].done;
      value_arr[i] = entries[i].value;
    end
  end

  // Storage, pointers and occupancy; squash has the same effect as reset.
  always_ff @(posedge clock) begin
    if (reset || rob.squash) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_SZ; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (cdb_write) begin
        entries[cdb_idx].done  <= 1'b1;
        entries[cdb_idx].value <= rob.cdb_value;
      end
      // Retire is ordered after the CDB write so a late write cannot revive the head.
      if (fire_ret) begin
        entries[head].busy <= 1'b0;
        entries[head].done <= 1'b0;
        head               <= head + IDX_W'(1);
      end
      if (fire_dp) begin
        entries[tail].busy     <= 1'b1;
        entries[tail].done     <= 1'b0;
        entries[tail].dest_reg <= rob.dp_dest_reg;
        entries[tail].has_dest <= rob.dp_has_dest;
        entries[tail].value    <= '0;
        tail                   <= tail + IDX_W'(1);
      end
      count_q <= count_q + CNT_W'(fire_dp) - CNT_W'(fire_ret);
    end
  end

  rob_dep_lookup u_dep_a (
    .tag       (rob.dep_tag_a),
    .busy_vec  (busy_vec),
    .done_vec  (done_vec),
    .value_arr (value_arr),
    .cdb_valid (rob.cdb_valid),
    .cdb_tag   (rob.cdb_tag),
    .cdb_value (rob.cdb_value),
    .ready     (ready_a),
    .value     (value_a)
  );

  rob_dep_lookup u_dep_b (
    .tag       (rob.dep_tag_b),
    .busy_vec  (busy_vec),
    .done_vec  (done_vec),
    .value_arr (value_arr),
    .cdb_valid (rob.cdb_valid),
    .cdb_tag   (rob.cdb_tag),
    .cdb_value (rob.cdb_value),
    .ready     (ready_b),
    .value     (value_b)
  );

  assign rs_pkt = '{dp_tag:  idx_to_tag(tail),
                    ready_a: ready_a, value_a: value_a,
                    ready_b: ready_b, value_b: value_b};

  assign rob.dp_ready    = dp_ready;
  assign rob.dp_tag      = rs_pkt.dp_tag;
  assign rob.dep_ready_a = rs_pkt.ready_a;
  assign rob.dep_value_a = rs_pkt.value_a;
  assign rob.dep_ready_b = rs_pkt.ready_b;
  assign rob.dep_value_b = rs_pkt.value_b;

  // Retire fields read as zero whenever nothing retires.
  assign rob.retire_valid    = fire_ret;
  assign rob.retire_tag      = fire_ret ? idx_to_tag(head) : '0;
  assign rob.retire_dest_reg = fire_ret ? entries[head].dest_reg : '0;
  assign rob.retire_has_dest = fire_ret && entries[head].has_dest;
  assign rob.retire_value    = fire_ret ? entries[head].value : '0;
  assign rob.count           = count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with an in-order retire scoreboard and a
// per-cycle reference model of occupancy, tags and operand lookups.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reorder_buffer_if bus ();
  reorder_buffer dut (.clock(clk), .reset(rst), .rob(bus.slave));

  typedef struct {
    int         tag;
    logic [4:0] dest;
    logic       has_dest;
  } exp_t;

  exp_t        sbq[$];
  logic        mdone [16];
  logic [31:0] mval  [16];
  int          exp_cnt;
  int          exp_tail;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  function automatic bit in_q(input int t);
    foreach (sbq[i]) if (sbq[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void exp_dep(input int t, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = '0;
    if (t != 0 && in_q(t)) begin
      if (bus.cdb_valid && int'(bus.cdb_tag) == t) begin
        r = 1'b1; v = bus.cdb_value;
      end else if (mdone[t]) begin
        r = 1'b1; v = mval[t];
      end
    end
  endfunction

  task automatic model_clear();
    sbq.delete();
    exp_cnt  = 0;
    exp_tail = 0;
    for (int i = 0; i < 16; i++) begin mdone[i] = 1'b0; mval[i] = '0; end
  endtask

  task automatic idle_inputs();
    bus.dp_valid = 0; bus.dp_dest_reg = '0; bus.dp_has_dest = 0;
    bus.dep_tag_a = '0; bus.dep_tag_b = '0;
    bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_value = '0;
    bus.squash = 0;
  endtask

  // Check combinational outputs mid-cycle, clock once, then advance the model.
  task automatic cycle(input string name);
    logic er, fd, r;
    logic [31:0] v;
    int t;
    #1;
    chk({name, ".count"}, bus.count, exp_cnt);
    chk({name, ".dp_ready"}, bus.dp_ready, exp_cnt < ROB_SZ);
    chk({name, ".dp_tag"}, bus.dp_tag, exp_tail + 1);
    er = !bus.squash && sbq.size() > 0 && mdone[sbq[0].tag];
    chk({name, ".retire_valid"}, bus.retire_valid, er);
    if (er) begin
      chk({name, ".retire_tag"}, bus.retire_tag, sbq[0].tag);
      chk({name, ".retire_dest"}, bus.retire_dest_reg, sbq[0].dest);
      chk({name, ".retire_has_dest"}, bus.retire_has_dest, sbq[0].has_dest);
      chk({name, ".retire_value"}, bus.retire_value, mval[sbq[0].tag]);
    end
    exp_dep(int'(bus.dep_tag_a), r, v);
    chk({name, ".dep_ready_a"}, bus.dep_ready_a, r);
    chk({name, ".dep_value_a"}, bus.dep_value_a, v);
    exp_dep(int'(bus.dep_tag_b), r, v);
    chk({name, ".dep_ready_b"}, bus.dep_ready_b, r);
    chk({name, ".dep_value_b"}, bus.dep_value_b, v);
    @(posedge clk);
    if (rst || bus.squash) begin
      model_clear();
    end else begin
      fd = bus.dp_valid && exp_cnt < ROB_SZ;
      t  = int'(bus.cdb_tag);
      if (bus.cdb_valid && t != 0 && in_q(t)) begin mdone[t] = 1'b1; mval[t] = bus.cdb_value; end
      if (er) begin mdone[sbq[0].tag] = 1'b0; void'(sbq.pop_front()); exp_cnt--; end
      if (fd) begin
        t = exp_tail + 1;
        sbq.push_back('{tag: t, dest: bus.dp_dest_reg, has_dest: bus.dp_has_dest});
        mdone[t] = 1'b0; mval[t] = '0;
        exp_tail = (exp_tail + 1) % ROB_SZ;
        exp_cnt++;
      end
    end
    #1;
  endtask

  task automatic dp(input logic [4:0] d, input logic hd);
    bus.dp_valid = 1; bus.dp_dest_reg = d; bus.dp_has_dest = hd;
    cycle("dp");
    bus.dp_valid = 0;
  endtask

  task automatic cdb(input int t, input logic [31:0] v);
    bus.cdb_valid = 1; bus.cdb_tag = ROB_TAG'(t); bus.cdb_value = v;
    cycle("cdb");
    bus.cdb_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle("idle");
  endtask

  task automatic do_reset();
    rst = 1; cycle("reset"); rst = 0;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst.dp_ready", bus.dp_ready, 1);
    chk("rst.dp_tag", bus.dp_tag, 1);
    chk("rst.count", bus.count, 0);
    chk("rst.retire_valid", bus.retire_valid, 0);
    chk("rst.retire_tag", bus.retire_tag, 0);
    chk("rst.retire_value", bus.retire_value, 0);
    chk("rst.dep_ready_a", bus.dep_ready_a, 0);

    // 1: fill to capacity, then a refused ninth dispatch
    for (int i = 1; i <= 8; i++) dp(5'(i), 1'b1);
    chk("t1.count", bus.count, 8);
    chk("t1.dp_ready", bus.dp_ready, 0);
    dp(5'd9, 1'b1);
    chk("t1.count_after_9th", bus.count, 8);

    // 2: out-of-order completion, in-order retire
    do_reset();
    dp(5'd10, 1'b1); dp(5'd11, 1'b0); dp(5'd12, 1'b1);
    cdb(2, 32'h22);
    cdb(1, 32'h11);
    chk("t2.retire1_tag", bus.retire_tag, 1);
    idle(4);
    chk("t2.tag3_waiting", bus.count, 1);
    cdb(3, 32'h33);
    idle(2);
    chk("t2.empty", bus.count, 0);

    // 3: full ROB with done head: dispatch refused while retire frees a slot
    do_reset();
    for (int i = 1; i <= 8; i++) dp(5'(i + 16), 1'b1);
    cdb(1, 32'h101);
    bus.dp_valid = 1; bus.dp_dest_reg = 5'd30; bus.dp_has_dest = 1;
    cycle("t3.full_retire");
    chk("t3.count7", bus.count, 7);
    chk("t3.wrapped_tag", bus.dp_tag, 1);
    cycle("t3.wrap_dp");
    bus.dp_valid = 0;
    chk("t3.count8", bus.count, 8);

    // 4: CDB bypass on lookup a, tag 0 on lookup b
    do_reset();
    for (int i = 1; i <= 4; i++) dp(5'(i), 1'b1);
    bus.dep_tag_a = ROB_TAG'(4); bus.dep_tag_b = '0;
    bus.cdb_valid = 1; bus.cdb_tag = ROB_TAG'(4); bus.cdb_value = 32'hABCD;
    #1;
    chk("t4.bypass_ready", bus.dep_ready_a, 1);
    chk("t4.bypass_value", bus.dep_value_a, 32'hABCD);
    chk("t4.tag0_ready", bus.dep_ready_b, 0);
    chk("t4.tag0_value", bus.dep_value_b, 0);
    cycle("t4.bypass");
    bus.cdb_valid = 0; bus.dep_tag_b = ROB_TAG'(6);
    cycle("t4.stored");
    bus.dep_tag_a = ROB_TAG'(2); bus.dep_tag_b = ROB_TAG'(12);
    cycle("t4.notdone");
    bus.dep_tag_a = '0; bus.dep_tag_b = '0;

    // 5: squash beats dispatch, CDB and retire
    do_reset();
    for (int i = 1; i <= 5; i++) dp(5'(i), 1'b1);
    cdb(1, 32'h5151);
    bus.squash = 1; bus.dp_valid = 1; bus.dp_dest_reg = 5'd7; bus.dp_has_dest = 1;
    bus.cdb_valid = 1; bus.cdb_tag = ROB_TAG'(3); bus.cdb_value = 32'h77;
    cycle("t5.squash");
    idle_inputs();
    chk("t5.count", bus.count, 0);
    chk("t5.dp_tag", bus.dp_tag, 1);
    chk("t5.retire_valid", bus.retire_valid, 0);
    cdb(3, 32'h333);
    dp(5'd3, 1'b1);
    idle(2);
    chk("t5.fresh_not_done", bus.count, 1);

    // 6: reset mid-stream with completed entries behind an incomplete head
    do_reset();
    for (int i = 1; i <= 4; i++) dp(5'(i), 1'b1);
    cdb(2, 32'h2); cdb(3, 32'h3); cdb(4, 32'h4);
    rst = 1;
    bus.cdb_valid = 1; bus.cdb_tag = ROB_TAG'(1); bus.cdb_value = 32'h1;
    cycle("t6.reset");
    rst = 0;
    idle_inputs();
    chk("t6.retire_valid", bus.retire_valid, 0);
    chk("t6.count", bus.count, 0);
    chk("t6.dp_tag", bus.dp_tag, 1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
